// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte FIFO buffering uart_rx frames for the interface
module uart_rx_fifo #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_wr,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_rd,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_full,
    output logic [NB_ADDR:0]   o_count,
    input  logic               i_clr_ovf,
    output logic               o_overflow
);

    localparam logic [NB_ADDR:0] DEPTH = (NB_ADDR+1)'(2**NB_ADDR);

    logic [NB_DATA-1:0] mem_q [2**NB_ADDR];
    logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [NB_ADDR:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               push_ok, pop_ok, drop;

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    always_comb begin
        pop_ok  = i_rd && (count_q != '0);
        push_ok = i_wr && ((count_q != DEPTH) || pop_ok);
        drop    = i_wr && !push_ok;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok) count_d = count_q + 1'b1;
        if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        // Setting on a dropped byte takes priority over a clear in the same cycle.
        if (drop)
            ovf_d = 1'b1;
        else if (i_clr_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is intentionally not reset; reset still blocks the write that cycle.
    always_ff @(posedge clk) begin
        if (!i_rst && push_ok)
            mem_q[wr_ptr_q] <= i_data;
    end

    assign o_data     = mem_q[rd_ptr_q];
    assign o_valid    = (count_q != '0);
    assign o_full     = (count_q == DEPTH);
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule
